// File: rtl/count_checker_pkg.sv
// Shared lab package: checker state encoding, parameter defaults and the
// expected-next-count helper.
package count_checker_pkg;

  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned ERR_W_DEF  = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned RUN_W      = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HUNT  = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  // Next value of a 4-bit counter: +1 when counting up, -1 when down (mod 16)
  function automatic logic [CNT_W-1:0] expect_next(input logic [CNT_W-1:0] prev,
                                                   input logic down);
    return down ? prev - CNT_W'(1) : prev + CNT_W'(1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus an edge flop; rise_pulse is high for one clk
// cycle after a rising edge of async_in reaches the clk domain.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/count_checker.sv
// Checks that a slow-clocked 4-bit counter steps by +/-1 each slow edge,
// declares lock after LOCK_N consecutive good steps and counts slips.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned LOCK_N = LOCK_N_DEF,
  parameter int unsigned ERR_W  = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic [3:0]       cnt,
  input  logic             mode,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       last
);

  state_e           state, state_d;
  logic [RUN_W-1:0] run, run_d, run_inc;
  logic [3:0]       last_d;
  logic [ERR_W-1:0] err_count_d;
  logic             err_d;
  logic             tick;
  logic             match;

  edge_sync u_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (slow_clk),
    .rise_pulse(tick)
  );

  assign run_inc = run + RUN_W'(1);
  assign match   = (cnt == expect_next(last, mode));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      run       <= '0;
      last      <= '0;
      err       <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      run       <= run_d;
      last      <= last_d;
      err       <= err_d;
      err_count <= err_count_d;
      locked    <= (state_d == ST_LOCK);
    end
  end

  // Everything holds between ticks; only a tick advances the tracker
  always_comb begin
    state_d     = state;
    run_d       = run;
    last_d      = last;
    err_d       = 1'b0;
    err_count_d = err_count;
    if (tick) begin
      last_d = cnt;
      unique case (state)
        ST_EMPTY: begin
          run_d   = '0;
          state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_N)) state_d = ST_LOCK;
          end else begin
            run_d = '0;
          end
        end
        ST_LOCK: begin
          if (!match) begin
            err_d   = 1'b1;
            run_d   = '0;
            state_d = ST_HUNT;
            if (err_count != {ERR_W{1'b1}}) err_count_d = err_count + ERR_W'(1);
          end
        end
        default: begin
          run_d   = '0;
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have parameter LOCK_N, default 4, meaning the number of consecutive correct samples required to declare lock (legal range 1..15).
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning the width of the saturating error counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports listed first:
  clk  input  1  system clock (CLOCK_50 domain)
  reset  input  1  synchronous active-high reset
  slow_clk  input  1  divided clock that drives the counter under test; asynchronous to clk
  cnt  input  4  counter value under test; changes only on slow_clk rising edge
  mode  input  1  expected direction: 0 = up (+1 mod 16), 1 = down (-1 mod 16)
  locked  output  1  high while the sequence is tracked correctly
  err  output  1  one-clk pulse on each mismatch seen while locked
  err_count  output  ERR_W  saturating count of err pulses
  last  output  4  most recently sampled cnt

Function
REQ-004 slow_clk SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3; internal tick = s2 AND NOT s3.
REQ-005 On a tick cycle, cnt SHALL be sampled; all outputs SHALL update at the clk edge that ends the tick cycle, which is the 3rd clk edge counting the edge that first samples slow_clk high as edge 1.
REQ-006 The expected value SHALL be last+1 mod 16 when mode=0 and last-1 mod 16 when mode=1; mode is evaluated in the tick cycle. Wrap-around cases 15->0 (up) and 0->15 (down) are correct.
REQ-007 FSM states: EMPTY (no sample held), HUNT (sample held, run counter counting), LOCK.
REQ-008 EMPTY: on tick, last<=cnt, run<=0, go to HUNT; no comparison performed.
REQ-009 HUNT: on tick with match, run<=run+1; when run+1 == LOCK_N, go to LOCK and assert locked. On tick with mismatch, run<=0 and remain in HUNT, with no err pulse.
REQ-010 LOCK: on tick with match, remain in LOCK. On tick with mismatch: err=1 for exactly one clk, err_count increments, run<=0, locked<=0, go to HUNT.
REQ-011 last SHALL be loaded with cnt on every tick in every state.
REQ-012 err_count SHALL saturate at 2^ERR_W-1; further mismatches still pulse err.
REQ-013 Between ticks, all state and outputs SHALL hold; err SHALL be 0.
REQ-014 locked SHALL be registered and equal (state == LOCK).

Reset
REQ-015 With reset high at a clk edge, the block SHALL clear: state=EMPTY, run=0, s1=s2=s3=0, locked=0, err=0, err_count=0, last=0.
REQ-016 Reset SHALL take priority over a simultaneous tick; that sample is discarded.
REQ-017 Reset asserted mid-run SHALL abandon the lock; the first tick after reset is treated as an EMPTY sample.
REQ-018 Because s3 clears on reset, a slow_clk already high at reset release SHALL produce one tick 2 edges later. This is accepted behaviour.

Structure
REQ-019 State encoding (EMPTY/HUNT/LOCK) and the default values of LOCK_N and ERR_W SHALL live in a shared lab package.
REQ-020 The synchronizer and edge detector SHALL be one sub-module, edge_sync (in: clk, reset, async_in; out: rise_pulse), reusable by other lab tops.
REQ-021 The checker SHALL be instantiable beside clkdiv and the counter on the DE1 top, with slow_clk driven from the same clks bit.

Verification
REQ-022 Scenario: reset, then mode=0, cnt=0,1,2,3,4 on successive slow_clk edges. Required: locked=1 after the 5th sample (4 matches), err_count=0.
REQ-023 Scenario: while locked (up), feed cnt 14,15,0,1. Required: locked stays 1 and err never asserts.
REQ-024 Scenario: while locked, feed cnt 5 then 7. Required: one-clk err pulse, err_count=1, locked=0, last=7; then 8,9,10,11 re-lock with no further err.
REQ-025 Scenario: mode=1, cnt 3,2,1,0,15. Required: locked=1 after cnt=15.
REQ-026 Scenario: ERR_W=2, alternate lock/mismatch 5 times. Required: err_count=3 held, and 5 err pulses observed.
REQ-027 Scenario: assert reset on the tick cycle while locked. Required: next cycle locked=0, err_count=0, last=0, state EMPTY; the following 5 correct samples re-lock.
